test_seq: RTL and testbench
===========================

TEST_SEQ -- requirements
Module: test_seq

Interface
REQ-001 The block SHALL have parameter N_STAGES, default 16, giving the number of chained test units (1..32).
REQ-002 The block SHALL have parameter TIMEOUT, default 1048575, giving the maximum wait cycles per stage (fits 20 bits).
REQ-003 The block SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port go  input  1  run request, sampled on clk.
REQ-006 The block SHALL have port start  output  N_STAGES  per-stage start level driven to each test unit.
REQ-007 The block SHALL have port finish  input  N_STAGES  per-stage finish level returned by each test unit.
REQ-008 The block SHALL have port busy  output  1  run in progress.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse at run end.
REQ-010 The block SHALL have port fail  output  1  sticky; last run aborted on timeout.
REQ-011 The block SHALL have port fail_idx  output  5  stage index that timed out.
REQ-012 The block SHALL have port cur_idx  output  5  stage currently being waited on.
REQ-013 The block SHALL have port run_cycles  output  32  total cycles of the last run, go-accept to done inclusive.

Function
REQ-014 The FSM SHALL have states IDLE, CLEAR, ISSUE, WAIT, DONE.
REQ-015 In IDLE with go=1, the FSM SHALL go to CLEAR, set busy=1, clear fail, fail_idx, cur_idx and the run counter.
REQ-016 CLEAR SHALL drive start to all zeros for exactly one cycle, then go to ISSUE.
REQ-017 ISSUE SHALL set start[cur_idx]=1, clear the stage wait counter, then go to WAIT next cycle.
REQ-018 Starts SHALL be cumulative: start[k] for k<=cur_idx stays 1 until the next CLEAR or reset.
REQ-019 In WAIT, finish[cur_idx]=1 SHALL advance: if cur_idx==N_STAGES-1, go to DONE; otherwise increment cur_idx and go to ISSUE.
REQ-020 The minimum per-stage latency SHALL be 2 cycles (ISSUE + WAIT), so a unit that returns finish immediately still costs 2 cycles.
REQ-021 Finish bits of stages other than cur_idx SHALL be ignored.
REQ-022 DONE SHALL pulse done=1 for one cycle, latch run_cycles, clear busy, and return to IDLE.
REQ-023 go while busy=1 SHALL be ignored; go held high in IDLE after DONE SHALL start a new run.
REQ-024 The run counter SHALL saturate at 0xFFFFFFFF rather than wrap.
REQ-025 cur_idx SHALL hold its final value in IDLE until the next run.

Reset
REQ-026 Reset SHALL asynchronously force state=IDLE, start=0, busy=0, done=0, fail=0, fail_idx=0, cur_idx=0, run_cycles=0 and all counters to 0.
REQ-027 Reset asserted mid-run SHALL abort the run with no done pulse; the first run after deassertion SHALL behave identically to the first run after power-up.

Configuration
REQ-028 Macro TEST_SEQ_TIMEOUT_EN SHALL compile in the watchdog.
- Defined: in WAIT the stage counter increments each cycle. When it equals TIMEOUT with finish[cur_idx]=0, the FSM sets fail=1, sets fail_idx=cur_idx, and goes to DONE. If finish arrives in that same cycle, finish wins.
- Undefined: no stage counter exists, WAIT lasts indefinitely, and fail and fail_idx are constant 0.

Verification
REQ-029 N_STAGES=4, every finish[i] tied to start[i], go pulsed -> start steps 0001,0011,0111,1111 every 2 cycles; done 1 cycle after last WAIT; run_cycles=10; fail=0.
REQ-030 With TEST_SEQ_TIMEOUT_EN, TIMEOUT=8, N_STAGES=4, finish[2] stuck 0 -> fail=1, fail_idx=2, start=0111 held, done pulses once, busy=0.
REQ-031 finish[3] forced 1 before the run -> stage 3 still waits for ISSUE and WAIT; no stage is skipped; finish[3] during stage 1 has no effect.
REQ-032 Reset asserted during WAIT of stage 1 -> all outputs 0 immediately with no done pulse; the next go gives the same trace as REQ-029.
REQ-033 go held high continuously -> back-to-back runs, each beginning with a one-cycle all-zero start (CLEAR); go pulses during busy are not queued.
REQ-034 Without TEST_SEQ_TIMEOUT_EN, finish[0] held 0 for 10000 cycles -> busy stays 1, fail=0; releasing finish[0]=1 resumes normal sequencing.

Source files
------------

// File: rtl/test_seq.sv
// test_seq: sequences a chain of N_STAGES test units. Each stage gets a
// cumulative start level and the sequencer waits for that stage's finish
// before moving on. A run ends with a one-cycle done pulse and the run length
// latched into run_cycles.
//
// Build option: define TEST_SEQ_TIMEOUT_EN to compile in a per-stage watchdog
// that aborts the run (fail/fail_idx) after TIMEOUT wait cycles. Without it,
// a stage may wait forever and fail/fail_idx are tied to 0.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | not running; cur_idx and run_cycles hold the last run result
// CLEAR | all start levels low for one cycle, first stage selected
// ISSUE | start[cur_idx] visible to the unit; wait counter cleared
// WAIT  | waiting for finish[cur_idx] (or the watchdog, if compiled in)
// DONE  | done pulse high, run_cycles valid; back to IDLE next cycle
module test_seq #(
  parameter int N_STAGES = 16,
  parameter int TIMEOUT  = 1048575
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  output logic [N_STAGES-1:0] start,
  input  logic [N_STAGES-1:0] finish,
  output logic                busy,
  output logic                done,
  output logic                fail,
  output logic [4:0]          fail_idx,
  output logic [4:0]          cur_idx,
  output logic [31:0]         run_cycles
);

  // Out-of-range parameters are rejected at elaboration.
  if (N_STAGES < 1 || N_STAGES > 32 || TIMEOUT < 0 || TIMEOUT > 1048575) begin : g_bad_params
    $error("test_seq: N_STAGES must be 1..32 and TIMEOUT must fit in 20 bits");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [4:0]          LAST_IDX = 5'(N_STAGES - 1);
  localparam logic [N_STAGES-1:0] STAGE0   = N_STAGES'(1);

  state_t              state_q, state_d;
  logic [N_STAGES-1:0] start_q, start_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [4:0]          cur_idx_q, cur_idx_d;
  logic [31:0]         run_cnt_q, run_cnt_d;
  logic [31:0]         run_cycles_q, run_cycles_d;
  logic [31:0]         run_inc;
  logic                cur_finish;

`ifdef TEST_SEQ_TIMEOUT_EN
  localparam logic [19:0] TIMEOUT_CNT = 20'(TIMEOUT);

  logic [19:0] stage_cnt_q, stage_cnt_d;
  logic        fail_q, fail_d;
  logic [4:0]  fail_idx_q, fail_idx_d;
`endif

  // Only the finish bit of the stage being waited on matters.
  assign cur_finish = |(finish & (STAGE0 << cur_idx_q));

  // Run counter saturates instead of wrapping. It starts at 1 on go-accept,
  // so the value latched on leaving WAIT is the full run length.
  assign run_inc = (run_cnt_q == 32'hFFFF_FFFF) ? run_cnt_q : run_cnt_q + 32'd1;

  // Next-state and output decode; every register holds unless told otherwise.
  always_comb begin
    state_d      = state_q;
    start_d      = start_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    cur_idx_d    = cur_idx_q;
    run_cnt_d    = run_cnt_q;
    run_cycles_d = run_cycles_q;
`ifdef TEST_SEQ_TIMEOUT_EN
    stage_cnt_d  = stage_cnt_q;
    fail_d       = fail_q;
    fail_idx_d   = fail_idx_q;
`endif

    case (state_q)
      IDLE: begin
        if (go) begin
          state_d   = CLEAR;
          busy_d    = 1'b1;
          start_d   = '0;
          cur_idx_d = '0;
          run_cnt_d = 32'd1;
`ifdef TEST_SEQ_TIMEOUT_EN
          fail_d     = 1'b0;
          fail_idx_d = '0;
`endif
        end
      end

      CLEAR: begin
        state_d   = ISSUE;
        run_cnt_d = run_inc;
      end

      ISSUE: begin
        state_d   = WAIT;
        run_cnt_d = run_inc;
`ifdef TEST_SEQ_TIMEOUT_EN
        stage_cnt_d = '0;
`endif
      end

      WAIT: begin
        run_cnt_d = run_inc;
        // finish is checked first so it wins over a same-cycle timeout
        if (cur_finish) begin
          if (cur_idx_q == LAST_IDX) begin
            state_d      = DONE;
            done_d       = 1'b1;
            run_cycles_d = run_inc;
          end else begin
            state_d   = ISSUE;
            cur_idx_d = cur_idx_q + 5'd1;
          end
        end
`ifdef TEST_SEQ_TIMEOUT_EN
        else if (stage_cnt_q == TIMEOUT_CNT) begin
          state_d      = DONE;
          done_d       = 1'b1;
          run_cycles_d = run_inc;
          fail_d       = 1'b1;
          fail_idx_d   = cur_idx_q;
        end else begin
          stage_cnt_d = stage_cnt_q + 20'd1;
        end
`endif
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // The start bit is registered on the way into ISSUE so the unit sees it
    // during ISSUE itself, keeping CLEAR as the only all-zero cycle.
    if (state_d == ISSUE) begin
      start_d = start_q | (STAGE0 << cur_idx_d);
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      start_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cur_idx_q    <= '0;
      run_cnt_q    <= '0;
      run_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cur_idx_q    <= cur_idx_d;
      run_cnt_q    <= run_cnt_d;
      run_cycles_q <= run_cycles_d;
    end
  end

`ifdef TEST_SEQ_TIMEOUT_EN
  // Watchdog counter and sticky failure record.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_cnt_q <= '0;
      fail_q      <= 1'b0;
      fail_idx_q  <= '0;
    end else begin
      stage_cnt_q <= stage_cnt_d;
      fail_q      <= fail_d;
      fail_idx_q  <= fail_idx_d;
    end
  end

  assign fail     = fail_q;
  assign fail_idx = fail_idx_q;
`else
  assign fail     = 1'b0;
  assign fail_idx = 5'd0;
`endif

  assign start      = start_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cur_idx    = cur_idx_q;
  assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_test_seq.sv
// Bench for test_seq with four stages and a short watchdog. Each test unit is
// modelled as returning finish as soon as it sees start, with per-bit
// overrides to hold a finish low (stuck0) or force it high (stuck1).
module tb_test_seq;
  localparam int NS = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          go;
  logic [NS-1:0] start;
  logic [NS-1:0] finish;
  logic [NS-1:0] stuck0;
  logic [NS-1:0] stuck1;
  logic          busy;
  logic          done;
  logic          fail;
  logic [4:0]    fail_idx;
  logic [4:0]    cur_idx;
  logic [31:0]   run_cycles;

  int n_total  = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int d0;

  typedef struct {
    logic [31:0] rc;
    logic        f;
    logic [4:0]  fi;
    logic [4:0]  ci;
  } exp_t;

  exp_t sb[$];

  test_seq #(.N_STAGES(NS), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .go         (go),
    .start      (start),
    .finish     (finish),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .fail_idx   (fail_idx),
    .cur_idx    (cur_idx),
    .run_cycles (run_cycles)
  );

  assign finish = (start & ~stuck0) | stuck1;

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic push_exp(input logic [31:0] rc, input logic f, input logic [4:0] fi,
                          input logic [4:0] ci);
    exp_t e;
    e.rc = rc;
    e.f  = f;
    e.fi = fi;
    e.ci = ci;
    sb.push_back(e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_start"},      32'(start),    32'd0);
    chk({tag, "_busy"},       32'(busy),     32'd0);
    chk({tag, "_done"},       32'(done),     32'd0);
    chk({tag, "_fail"},       32'(fail),     32'd0);
    chk({tag, "_fail_idx"},   32'(fail_idx), 32'd0);
    chk({tag, "_cur_idx"},    32'(cur_idx),  32'd0);
    chk({tag, "_run_cycles"}, run_cycles,    32'd0);
  endtask

  // Waits (bounded) for the done pulse, then compares the oldest expected
  // run result and checks that busy/done drop on the following cycle.
  task automatic wait_done(input string tag, input int budget);
    exp_t e;
    for (int i = 0; i < budget && done !== 1'b1; i++) tick();
    chk({tag, "_done"}, 32'(done), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_run_cycles"}, run_cycles,       e.rc);
      chk({tag, "_fail"},       32'(fail),        32'(e.f));
      chk({tag, "_fail_idx"},   32'(fail_idx),    32'(e.fi));
      chk({tag, "_cur_idx"},    32'(cur_idx),     32'(e.ci));
    end
    tick();
    chk({tag, "_busy_clr"}, 32'(busy), 32'd0);
    chk({tag, "_done_clr"}, 32'(done), 32'd0);
  endtask

  // Full cycle-by-cycle trace of a run where every unit answers at once:
  // CLEAR with start=0, then two cycles per stage with a growing start mask.
  task automatic run_trace(input string tag, input bit hold_go);
    logic [NS-1:0] m;
    go = 1'b1;
    push_exp(32'd10, 1'b0, 5'd0, 5'(NS - 1));
    tick();
    if (!hold_go) go = 1'b0;
    chk({tag, "_clr_start"}, 32'(start),   32'd0);
    chk({tag, "_clr_busy"},  32'(busy),    32'd1);
    chk({tag, "_clr_cur"},   32'(cur_idx), 32'd0);
    chk({tag, "_clr_fail"},  32'(fail),    32'd0);
    for (int k = 0; k < NS; k++) begin
      m = NS'((1 << (k + 1)) - 1);
      for (int ph = 0; ph < 2; ph++) begin
        tick();
        chk({tag, $sformatf("_start_s%0d_p%0d", k, ph)}, 32'(start),   32'(m));
        chk({tag, $sformatf("_cur_s%0d_p%0d", k, ph)},   32'(cur_idx), 32'(k));
        chk({tag, $sformatf("_done_s%0d_p%0d", k, ph)},  32'(done),    32'd0);
      end
    end
    tick();
    wait_done(tag, 0);
  endtask

  initial begin
    reset  = 1'b1;
    go     = 1'b0;
    stuck0 = '0;
    stuck1 = '0;
    tick();
    tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();

    // Plain run, then cur_idx and run_cycles must hold in IDLE.
    run_trace("basic", 1'b0);
    repeat (3) tick();
    chk("idle_hold_cur",  32'(cur_idx), 32'(NS - 1));
    chk("idle_hold_rc",   run_cycles,   32'd10);
    chk("idle_hold_busy", 32'(busy),    32'd0);

    // finish[3] high from the start: nothing may be skipped.
    stuck1 = 4'b1000;
    tick();
    run_trace("fin3_forced", 1'b0);
    stuck1 = '0;
    tick();

    // Reset while waiting on stage 1: immediate clear, no done pulse.
    d0 = done_cnt;
    go = 1'b1;
    tick();
    go = 1'b0;
    repeat (4) tick();
    chk("mid_cur",   32'(cur_idx), 32'd1);
    chk("mid_start", 32'(start),   32'b0011);
    reset = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    tick();
    tick();
    chk("mid_reset_no_done", 32'(done_cnt), 32'(d0));
    reset = 1'b0;
    tick();
    run_trace("after_reset", 1'b0);

    // A go pulse while busy must not queue a second run.
    go = 1'b1;
    push_exp(32'd10, 1'b0, 5'd0, 5'(NS - 1));
    tick();
    go = 1'b0;
    tick();
    tick();
    go = 1'b1;
    tick();
    go = 1'b0;
    wait_done("busy_go", 50);
    d0 = done_cnt;
    repeat (5) tick();
    chk("busy_go_idle",     32'(busy),     32'd0);
    chk("busy_go_no_queue", 32'(done_cnt), 32'(d0));

    // go held high: back-to-back runs, each with its own CLEAR cycle.
    run_trace("b2b_1", 1'b1);
    chk("b2b_idle_start", 32'(start), 32'b1111);
    run_trace("b2b_2", 1'b1);
    go = 1'b0;
    tick();

`ifdef TEST_SEQ_TIMEOUT_EN
    // Stage 2 never finishes: watchdog aborts after TO+1 wait cycles.
    stuck0 = 4'b0100;
    d0 = done_cnt;
    go = 1'b1;
    push_exp(32'(8 + TO), 1'b1, 5'd2, 5'd2);
    tick();
    go = 1'b0;
    wait_done("timeout", 100);
    chk("timeout_start", 32'(start), 32'b0111);
    repeat (3) tick();
    chk("timeout_one_done",  32'(done_cnt), 32'(d0 + 1));
    chk("timeout_fail_held", 32'(fail),     32'd1);
    chk("timeout_idx_held",  32'(fail_idx), 32'd2);

    // Stage 1 finish arrives exactly when the counter reaches TIMEOUT.
    stuck0 = 4'b0010;
    go = 1'b1;
    push_exp(32'(10 + TO), 1'b0, 5'd0, 5'(NS - 1));
    tick();
    go = 1'b0;
    chk("fw_fail_cleared", 32'(fail), 32'd0);
    repeat (4 + TO) tick();
    chk("fw_cur", 32'(cur_idx), 32'd1);
    stuck0 = '0;
    wait_done("finish_wins", 50);
`else
    // No watchdog: stage 0 waits as long as finish stays low.
    stuck0 = 4'b0001;
    go = 1'b1;
    push_exp(32'd10008, 1'b0, 5'd0, 5'(NS - 1));
    tick();
    go = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      tick();
      if (i % 1000 == 999) begin
        chk($sformatf("nowd_busy_%0d", i), 32'(busy),    32'd1);
        chk($sformatf("nowd_fail_%0d", i), 32'(fail),    32'd0);
        chk($sformatf("nowd_cur_%0d", i),  32'(cur_idx), 32'd0);
      end
    end
    stuck0 = '0;
    wait_done("no_watchdog", 50);
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
